// File: rtl/nibble_packer_pkg.sv
// Shared definitions for the nibble packer: data widths and FSM state encoding.
package nibble_packer_pkg;

    localparam int BLK_W = 12;
    localparam int NIB_W = 4;

    // FSM states: number of nibbles currently held, FULL = complete block on offer
    localparam logic [1:0] S0   = 2'd0;
    localparam logic [1:0] S1   = 2'd1;
    localparam logic [1:0] S2   = 2'd2;
    localparam logic [1:0] FULL = 2'd3;

endpackage

// File: rtl/nibble_packer_key_holder.sv
// Key register for the downstream core. A key load while a block is on offer
// is parked in a pending register so key_out never changes under a held block;
// the parked value (or a coincident fresh load) is applied on the block transfer.
module nibble_packer_key_holder
    import nibble_packer_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [BLK_W-1:0] key_in,
    input  logic             key_load,
    input  logic             full,
    input  logic             blk_xfer,
    output logic [BLK_W-1:0] key_out
);

    logic [BLK_W-1:0] pend_key;
    logic             pend_flag;

    // Update live key directly when idle, otherwise defer until the block leaves
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_out   <= '0;
            pend_key  <= '0;
            pend_flag <= 1'b0;
        end else if (!full) begin
            if (key_load) begin
                key_out <= key_in;
            end
        end else if (blk_xfer) begin
            if (key_load) begin
                key_out <= key_in;
            end else if (pend_flag) begin
                key_out <= pend_key;
            end
            pend_flag <= 1'b0;
        end else if (key_load) begin
            pend_key  <= key_in;
            pend_flag <= 1'b1;
        end
    end

endmodule

// File: rtl/nibble_packer.sv
// Packs three 4-bit nibbles into a 12-bit block for a downstream encryption
// core, with a valid/ready handshake on both sides, a deferred key update
// and a delivered-block counter.
module nibble_packer
    import nibble_packer_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b1,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NIB_W-1:0] nib_in,
    input  logic             nib_valid,
    output logic             nib_ready,
    input  logic [BLK_W-1:0] key_in,
    input  logic             key_load,
    output logic [BLK_W-1:0] din_out,
    output logic [BLK_W-1:0] key_out,
    output logic             blk_valid,
    input  logic             blk_ready,
    output logic [CNT_W-1:0] blk_count
);

    logic [1:0] state;
    logic [1:0] next_state;
    logic       nib_xfer;
    logic       blk_xfer;

    // In FULL a nibble is only taken when the block leaves in the same cycle
    assign nib_ready = (state != FULL) || blk_ready;
    assign nib_xfer  = nib_valid && nib_ready;
    assign blk_xfer  = blk_valid && blk_ready;

    // Next-state logic: count nibbles up to FULL, restart on block departure
    always_comb begin
        next_state = state;
        case (state)
            S0:      if (nib_xfer) next_state = S1;
            S1:      if (nib_xfer) next_state = S2;
            S2:      if (nib_xfer) next_state = FULL;
            default: if (blk_xfer) next_state = nib_xfer ? S1 : S0;
        endcase
    end

    // State register and registered block-valid flag (set exactly in FULL)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S0;
            blk_valid <= 1'b0;
        end else begin
            state     <= next_state;
            blk_valid <= (next_state == FULL);
        end
    end

    // Shift accepted nibbles in; direction decides where the first one ends up
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            din_out <= '0;
        end else if (nib_xfer) begin
            if (MSB_FIRST) begin
                din_out <= {din_out[BLK_W-NIB_W-1:0], nib_in};
            end else begin
                din_out <= {nib_in, din_out[BLK_W-1:NIB_W]};
            end
        end
    end

    // Count delivered blocks, wrapping naturally at the counter width
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blk_count <= '0;
        end else if (blk_xfer) begin
            blk_count <= blk_count + 1'b1;
        end
    end

    nibble_packer_key_holder u_key_holder (
        .clk      (clk),
        .reset    (reset),
        .key_in   (key_in),
        .key_load (key_load),
        .full     (state == FULL),
        .blk_xfer (blk_xfer),
        .key_out  (key_out)
    );

endmodule

// File: tb/tb_nibble_packer.sv
// Self-checking bench for nibble_packer: directed scenarios plus a randomized
// run compared against a queue-based behavioural model. Two instances share
// the inputs so both nibble orderings are observed.
module tb_nibble_packer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  nib_in = '0;
    logic        nib_valid = 1'b0;
    logic [11:0] key_in = '0;
    logic        key_load = 1'b0;
    logic        blk_ready = 1'b0;

    logic        nib_ready, blk_valid;
    logic [11:0] din_out, key_out;
    logic [7:0]  blk_count;
    logic        nib_ready_l, blk_valid_l;
    logic [11:0] din_out_l, key_out_l;
    logic [7:0]  blk_count_l;

    int checks = 0;
    int errors = 0;

    // behavioural model
    logic [3:0]  mq[$];
    logic [11:0] m_key, m_pend_key;
    bit          m_pend;
    logic [7:0]  m_count;

    always #5 clk = ~clk;

    nibble_packer #(.MSB_FIRST(1'b1), .CNT_W(8)) u_msb (
        .clk(clk), .reset(reset), .nib_in(nib_in), .nib_valid(nib_valid),
        .nib_ready(nib_ready), .key_in(key_in), .key_load(key_load),
        .din_out(din_out), .key_out(key_out), .blk_valid(blk_valid),
        .blk_ready(blk_ready), .blk_count(blk_count)
    );

    nibble_packer #(.MSB_FIRST(1'b0), .CNT_W(8)) u_lsb (
        .clk(clk), .reset(reset), .nib_in(nib_in), .nib_valid(nib_valid),
        .nib_ready(nib_ready_l), .key_in(key_in), .key_load(key_load),
        .din_out(din_out_l), .key_out(key_out_l), .blk_valid(blk_valid_l),
        .blk_ready(blk_ready), .blk_count(blk_count_l)
    );

    task automatic drive(input bit nv, input logic [3:0] n, input bit kl,
                         input logic [11:0] k, input bit br);
        nib_valid = nv;
        nib_in    = n;
        key_load  = kl;
        key_in    = k;
        blk_ready = br;
    endtask

    task automatic model_reset;
        mq.delete();
        m_key      = '0;
        m_pend_key = '0;
        m_pend     = 0;
        m_count    = '0;
    endtask

    // Apply the handshake rules to the inputs present at this clock edge
    task automatic model_step;
        bit full, rdy, nx, bx;
        full = (mq.size() == 3);
        rdy  = !full || blk_ready;
        nx   = nib_valid && rdy;
        bx   = full && blk_ready;
        if (bx) begin
            if (key_load) m_key = key_in;
            else if (m_pend) m_key = m_pend_key;
            m_pend = 0;
        end else if (key_load) begin
            if (full) begin
                m_pend_key = key_in;
                m_pend     = 1;
            end else begin
                m_key = key_in;
            end
        end
        if (bx) begin
            mq.delete();
            m_count = m_count + 8'd1;
        end
        if (nx) mq.push_back(nib_in);
    endtask

    task automatic tick;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset;
        #2 reset = 1'b1;
        model_reset();
        #3;
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        drive(0, 4'h0, 0, 12'h000, 0);
        #2 reset = 1'b1;
        model_reset();
        #2;
        checks++;
        if (blk_valid !== 1'b0 || din_out !== 12'h000 || key_out !== 12'h000 || blk_count !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_values: bv=%b din=%h key=%h cnt=%h required 0/000/000/00",
                     blk_valid, din_out, key_out, blk_count);
        end
        #3 reset = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (nib_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_nib_ready: got %b required 1", nib_ready);
        end
    endtask

    task automatic test_first_block;
        drive(0, 4'h0, 1, 12'hACD, 0);
        tick();
        checks++;
        if (key_out !== 12'hACD) begin
            errors++;
            $display("[TB] FAIL key_load_idle: got %h required acd", key_out);
        end
        drive(1, 4'hD, 0, 12'h000, 0);
        tick();
        drive(1, 4'h5, 0, 12'h000, 0);
        tick();
        checks++;
        if (blk_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL early_valid: got %b required 0", blk_valid);
        end
        drive(1, 4'hB, 0, 12'h000, 0);
        tick();
        checks++;
        if (blk_valid !== 1'b1 || din_out !== 12'hD5B || key_out !== 12'hACD || nib_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL first_block: bv=%b din=%h key=%h rdy=%b required 1/d5b/acd/0",
                     blk_valid, din_out, key_out, nib_ready);
        end
        checks++;
        if (din_out_l !== 12'hB5D) begin
            errors++;
            $display("[TB] FAIL lsb_order: got %h required b5d", din_out_l);
        end
    endtask

    task automatic test_ignored_while_full;
        for (int i = 0; i < 3; i++) begin
            drive(1, 4'(i + 7), 0, 12'h000, 0);
            tick();
        end
        checks++;
        if (blk_valid !== 1'b1 || din_out !== 12'hD5B || blk_count !== 8'h00) begin
            errors++;
            $display("[TB] FAIL hold_full: bv=%b din=%h cnt=%h required 1/d5b/00",
                     blk_valid, din_out, blk_count);
        end
    endtask

    task automatic test_pass_through;
        drive(1, 4'h9, 0, 12'h000, 1);
        #1;
        checks++;
        if (nib_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL pass_ready: got %b required 1", nib_ready);
        end
        tick();
        checks++;
        if (blk_count !== 8'h01 || blk_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL pass_xfer: cnt=%h bv=%b required 01/0", blk_count, blk_valid);
        end
        drive(1, 4'h9, 0, 12'h000, 0);
        tick();
        drive(1, 4'hA, 0, 12'h000, 0);
        tick();
        checks++;
        if (blk_valid !== 1'b1 || din_out !== 12'h99A || din_out_l !== 12'hA99) begin
            errors++;
            $display("[TB] FAIL pass_next_block: bv=%b din=%h lsb=%h required 1/99a/a99",
                     blk_valid, din_out, din_out_l);
        end
    endtask

    task automatic fill_block(input logic [11:0] nibs);
        logic [11:0] v;
        v = nibs;
        for (int i = 0; i < 3; i++) begin
            drive(1, v[11:8], 0, 12'h000, 0);
            v = v << 4;
            tick();
        end
        drive(0, 4'h0, 0, 12'h000, 0);
    endtask

    task automatic test_key_pending;
        drive(0, 4'h0, 1, 12'h92D, 0);
        tick();
        drive(0, 4'h0, 0, 12'h000, 0);
        tick();
        checks++;
        if (key_out !== 12'hACD) begin
            errors++;
            $display("[TB] FAIL key_held: got %h required acd", key_out);
        end
        drive(0, 4'h0, 0, 12'h000, 1);
        tick();
        checks++;
        if (key_out !== 12'h92D || blk_count !== 8'h02) begin
            errors++;
            $display("[TB] FAIL key_applied: key=%h cnt=%h required 92d/02", key_out, blk_count);
        end
        // last pending load wins
        fill_block(12'h123);
        drive(0, 4'h0, 1, 12'h444, 0);
        tick();
        drive(0, 4'h0, 1, 12'h555, 0);
        tick();
        drive(0, 4'h0, 0, 12'h000, 1);
        tick();
        checks++;
        if (key_out !== 12'h555) begin
            errors++;
            $display("[TB] FAIL key_last_wins: got %h required 555", key_out);
        end
        // a load on the transfer edge beats the older pending value
        fill_block(12'h456);
        drive(0, 4'h0, 1, 12'h111, 0);
        tick();
        drive(0, 4'h0, 1, 12'h333, 1);
        tick();
        checks++;
        if (key_out !== 12'h333) begin
            errors++;
            $display("[TB] FAIL key_coincident: got %h required 333", key_out);
        end
    endtask

    task automatic test_count_wrap;
        int guard;
        guard = 0;
        while (m_count != 8'hFF && guard < 1200) begin
            drive(1, 4'($urandom_range(0, 15)), 0, 12'h000, 1);
            tick();
            guard++;
        end
        checks++;
        if (blk_count !== 8'hFF) begin
            errors++;
            $display("[TB] FAIL count_ff: got %h required ff", blk_count);
        end
        guard = 0;
        while (m_count == 8'hFF && guard < 6) begin
            drive(1, 4'($urandom_range(0, 15)), 0, 12'h000, 1);
            tick();
            guard++;
        end
        checks++;
        if (blk_count !== 8'h00 || m_count !== 8'h00) begin
            errors++;
            $display("[TB] FAIL count_wrap: got %h model %h required 00", blk_count, m_count);
        end
    endtask

    task automatic test_reset_mid_block;
        fill_block(12'h789);
        drive(0, 4'h0, 1, 12'h777, 0);
        tick();
        drive(1, 4'h1, 0, 12'h000, 1);
        tick();
        drive(1, 4'h2, 0, 12'h000, 0);
        tick();
        drive(0, 4'h0, 0, 12'h000, 0);
        do_reset();
        checks++;
        if (blk_valid !== 1'b0 || din_out !== 12'h000 || key_out !== 12'h000 ||
            blk_count !== 8'h00 || nib_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_mid: bv=%b din=%h key=%h cnt=%h rdy=%b required 0/000/000/00/1",
                     blk_valid, din_out, key_out, blk_count, nib_ready);
        end
        fill_block(12'hC0F);
        checks++;
        if (blk_valid !== 1'b1 || din_out !== 12'hC0F || din_out_l !== 12'hF0C || key_out !== 12'h000) begin
            errors++;
            $display("[TB] FAIL fresh_block: bv=%b din=%h lsb=%h key=%h required 1/c0f/f0c/000",
                     blk_valid, din_out, din_out_l, key_out);
        end
    endtask

    task automatic test_random;
        logic [11:0] exp_msb, exp_lsb;
        bit exp_bv, exp_rdy;
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)),
                  $urandom_range(0, 7) == 0, 12'($urandom_range(0, 4095)),
                  $urandom_range(0, 1) == 1);
            tick();
            exp_bv  = (mq.size() == 3);
            exp_rdy = !exp_bv || blk_ready;
            checks++;
            if (blk_valid !== exp_bv || blk_valid_l !== exp_bv || nib_ready !== exp_rdy ||
                key_out !== m_key || key_out_l !== m_key ||
                blk_count !== m_count || blk_count_l !== m_count) begin
                errors++;
                $display("[TB] FAIL random_ctrl[%0d]: bv=%b rdy=%b key=%h cnt=%h required %b/%b/%h/%h",
                         i, blk_valid, nib_ready, key_out, blk_count, exp_bv, exp_rdy, m_key, m_count);
            end
            if (exp_bv) begin
                exp_msb = {mq[0], mq[1], mq[2]};
                exp_lsb = {mq[2], mq[1], mq[0]};
                checks++;
                if (din_out !== exp_msb || din_out_l !== exp_lsb) begin
                    errors++;
                    $display("[TB] FAIL random_din[%0d]: msb=%h lsb=%h required %h/%h",
                             i, din_out, din_out_l, exp_msb, exp_lsb);
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_first_block();
        test_ignored_while_full();
        test_pass_through();
        test_key_pending();
        test_count_wrap();
        test_reset_mid_block();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/nibble_packer.md
NIBBLE_PACKER -- requirements
Module: nibble_packer

Interface
REQ-001 SHALL have parameter MSB_FIRST, default 1: 1 = first nibble lands in din_out[11:8]; 0 = first nibble lands in din_out[3:0].
REQ-002 SHALL have parameter CNT_W, default 8: width of the delivered-block counter.
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous active-high reset.
REQ-006 SHALL have port nib_in, input, 4 bits: plaintext nibble.
REQ-007 SHALL have port nib_valid, input, 1 bit: nib_in is valid.
REQ-008 SHALL have port nib_ready, output, 1 bit: packer accepts a nibble this cycle.
REQ-009 SHALL have port key_in, input, 12 bits: new key value.
REQ-010 SHALL have port key_load, input, 1 bit: one-cycle request to load key_in.
REQ-011 SHALL have port din_out, output, 12 bits: assembled block for the downstream 12-bit encryption core Din.
REQ-012 SHALL have port key_out, output, 12 bits: key for the downstream core Key.
REQ-013 SHALL have port blk_valid, output, 1 bit: din_out/key_out hold a complete block.
REQ-014 SHALL have port blk_ready, input, 1 bit: downstream consumes the block.
REQ-015 SHALL have port blk_count, output, CNT_W bits: number of blocks delivered, modulo 2^CNT_W.

Function
REQ-016 A nibble transfer SHALL occur on a rising edge with nib_valid & nib_ready; a block transfer SHALL occur with blk_valid & blk_ready.
REQ-017 The FSM SHALL have states S0, S1, S2 (0/1/2 nibbles held) and FULL: S0->S1->S2 on each transfer; S2->FULL on the third transfer.
REQ-018 nib_ready SHALL be 1 in S0, S1 and S2; in FULL it SHALL equal blk_ready (pass-through accept).
REQ-019 blk_valid SHALL be registered and equal 1 exactly in FULL; it asserts on the edge that accepts the third nibble (latency 1 cycle after that transfer).
REQ-020 In FULL, a block transfer without a nibble transfer SHALL go to S0; a block transfer with a simultaneous nibble transfer SHALL go to S1, with that nibble stored as the first nibble of the next block.
REQ-021 din_out SHALL be stable while blk_valid=1 and blk_ready=0; nibble ordering follows MSB_FIRST.
REQ-022 Nibbles presented while nib_ready=0 SHALL be ignored (no state change).
REQ-023 key_load outside FULL SHALL update key_out on the next edge.
REQ-024 key_load in FULL SHALL capture key_in into a pending register and set a pending flag; key_out SHALL take the pending value on the edge of the block transfer.
REQ-025 A later key_load in FULL SHALL overwrite the pending value (last wins).
REQ-026 If key_load coincides with the block transfer edge, key_in SHALL win over any older pending value.
REQ-027 blk_count SHALL increment by 1 on each block transfer and wrap from 2^CNT_W-1 to 0.

Reset
REQ-028 Reset SHALL set: state S0, din_out 12'h000, key_out 12'h000, pending flag 0, blk_valid 0, blk_count 0; nib_ready is 1 from the first cycle after reset.
REQ-029 Reset asserted mid-block SHALL discard partial nibbles and any pending key, with no block emitted.

Structure
REQ-030 A shared package SHALL hold the FSM state encoding, the block width (12) and the nibble width (4).
REQ-031 A sub-module key_holder (key_out register, pending register, pending flag) is natural; the rest is flat.

Verification
REQ-032 key_load with key_in=12'hACD, then nibbles D,5,B on consecutive cycles with blk_ready=0 -> blk_valid rises 1 cycle after nibble B; din_out=12'hD5B, key_out=12'hACD; state held.
REQ-033 MSB_FIRST=0, nibbles 9,9,A -> din_out=12'hA99.
REQ-034 In FULL with din_out=12'hD5B, blk_ready=1 and nibble 9 in the same cycle -> blk_count +1, state S1; next nibbles 9,A -> din_out=12'h99A.
REQ-035 In FULL, key_load 12'h92D with blk_ready=0 -> key_out remains 12'hACD; on the block transfer key_out=12'h92D.
REQ-036 blk_count=8'hFF, one block transfer -> blk_count=8'h00.
REQ-037 Reset after 2 nibbles -> all outputs at reset values; next 3 nibbles form a fresh block.
